// File: rtl/dmpresent_bus_initiator.sv
// Bus-master sequencer for the DMPRESENT slave: writes key and block, pulses load, waits, reads the digest.
// Optional key cache (skip rewriting an unchanged key) is built when DMPI_KEY_CACHE_EN is defined.
`timescale 1ns/1ps

module dmpresent_bus_initiator #(
   parameter int WAIT_CYCLES = 34
) (
   input  logic        clk,
   input  logic        iReset_n,
   input  logic        iStart,
   input  logic [79:0] iKey,
   input  logic [63:0] iBlock,
   output logic        oBusy,
   output logic        oDone,
   output logic [63:0] oDigest,
   output logic        oChipselect_n,
   output logic        oWrite_n,
   output logic        oRead_n,
   output logic [2:0]  oAddress,
   output logic [31:0] odat,
   input  logic [31:0] idat
);

   localparam logic [3:0] S_IDLE = 4'd0;
   localparam logic [3:0] S_WK3  = 4'd1;
   localparam logic [3:0] S_WK2  = 4'd2;
   localparam logic [3:0] S_WK1  = 4'd3;
   localparam logic [3:0] S_WD5  = 4'd4;
   localparam logic [3:0] S_WD4  = 4'd5;
   localparam logic [3:0] S_WLD  = 4'd6;
   localparam logic [3:0] S_CLR  = 4'd7;
   localparam logic [3:0] S_WAIT = 4'd8;
   localparam logic [3:0] S_RD7  = 4'd9;
   localparam logic [3:0] S_RD6  = 4'd10;
   localparam logic [3:0] S_CAP  = 4'd11;
   localparam logic [3:0] S_DONE = 4'd12;

   // Counter holds WAIT_CYCLES-1 down to 0, so it never needs to represent WAIT_CYCLES itself
   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int WAIT_LOAD_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
   localparam logic [CW-1:0] WAIT_LOAD = WAIT_LOAD_I[CW-1:0];

   logic [3:0]    r_state;
   logic [CW-1:0] r_waitCnt;
   logic [79:0]   r_key;
   logic [63:0]   r_block;

   logic [3:0]    w_nextState;
   logic          w_cacheHit;
   logic [79:0]   w_keySrc;
   logic [63:0]   w_blockSrc;
   logic          w_csN;
   logic          w_wrN;
   logic          w_rdN;
   logic [2:0]    w_addr;
   logic [31:0]   w_dat;

`ifdef DMPI_KEY_CACHE_EN
   logic [79:0] r_keyCopy;
   logic        r_keyValid;

   assign w_cacheHit = r_keyValid && (iKey == r_keyCopy);

   always_ff @(posedge clk or negedge iReset_n) begin
      if (!iReset_n) begin
         r_keyCopy  <= '0;
         r_keyValid <= 1'b0;
      end else if (r_state == S_WK1) begin
         r_keyCopy  <= r_key;
         r_keyValid <= 1'b1;
      end
   end
`else
   assign w_cacheHit = 1'b0;
`endif

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE: if (iStart) w_nextState = w_cacheHit ? S_WD5 : S_WK3;
         S_WK3:  w_nextState = S_WK2;
         S_WK2:  w_nextState = S_WK1;
         S_WK1:  w_nextState = S_WD5;
         S_WD5:  w_nextState = S_WD4;
         S_WD4:  w_nextState = S_WLD;
         S_WLD:  w_nextState = S_CLR;
         S_CLR:  w_nextState = (WAIT_CYCLES == 0) ? S_RD7 : S_WAIT;
         S_WAIT: if (r_waitCnt == '0) w_nextState = S_RD7;
         S_RD7:  w_nextState = S_RD6;
         S_RD6:  w_nextState = S_CAP;
         S_CAP:  w_nextState = S_DONE;
         S_DONE: w_nextState = S_IDLE;
         default: w_nextState = S_IDLE;
      endcase
   end

   // Bus outputs are registered from the next state; the first write leaves IDLE before the key is latched
   assign w_keySrc   = (r_state == S_IDLE) ? iKey   : r_key;
   assign w_blockSrc = (r_state == S_IDLE) ? iBlock : r_block;

   always_comb begin
      w_csN  = 1'b1;
      w_wrN  = 1'b1;
      w_rdN  = 1'b1;
      w_addr = 3'd0;
      w_dat  = 32'h0;
      case (w_nextState)
         S_WK3: begin
            w_csN  = 1'b0;
            w_wrN  = 1'b0;
            w_addr = 3'd3;
            w_dat  = w_keySrc[79:48];
         end
         S_WK2: begin
            w_csN  = 1'b0;
            w_wrN  = 1'b0;
            w_addr = 3'd2;
            w_dat  = w_keySrc[47:16];
         end
         S_WK1: begin
            w_csN  = 1'b0;
            w_wrN  = 1'b0;
            w_addr = 3'd1;
            w_dat  = {16'h0, w_keySrc[15:0]};
         end
         S_WD5: begin
            w_csN  = 1'b0;
            w_wrN  = 1'b0;
            w_addr = 3'd5;
            w_dat  = w_blockSrc[63:32];
         end
         S_WD4: begin
            w_csN  = 1'b0;
            w_wrN  = 1'b0;
            w_addr = 3'd4;
            w_dat  = w_blockSrc[31:0];
         end
         S_WLD: begin
            w_csN  = 1'b0;
            w_wrN  = 1'b0;
            w_addr = 3'd0;
            w_dat  = 32'h1;
         end
         S_CLR: begin
            w_csN  = 1'b0;
            w_addr = 3'd0;
         end
         S_RD7: begin
            w_csN  = 1'b0;
            w_rdN  = 1'b0;
            w_addr = 3'd7;
         end
         S_RD6: begin
            w_csN  = 1'b0;
            w_rdN  = 1'b0;
            w_addr = 3'd6;
         end
         default: begin
            w_csN  = 1'b1;
         end
      endcase
   end

   // Read data arrives one cycle after each strobe, hence capture in RD6 (word 7) and CAP (word 6)
   always_ff @(posedge clk or negedge iReset_n) begin
      if (!iReset_n) begin
         r_state       <= S_IDLE;
         r_waitCnt     <= '0;
         r_key         <= '0;
         r_block       <= '0;
         oBusy         <= 1'b0;
         oDone         <= 1'b0;
         oDigest       <= '0;
         oChipselect_n <= 1'b1;
         oWrite_n      <= 1'b1;
         oRead_n       <= 1'b1;
         oAddress      <= 3'd0;
         odat          <= 32'h0;
      end else begin
         r_state       <= w_nextState;
         oBusy         <= (w_nextState != S_IDLE);
         oDone         <= (w_nextState == S_DONE);
         oChipselect_n <= w_csN;
         oWrite_n      <= w_wrN;
         oRead_n       <= w_rdN;
         oAddress      <= w_addr;
         odat          <= w_dat;
         if ((r_state == S_IDLE) && iStart) begin
            r_key   <= iKey;
            r_block <= iBlock;
         end
         if (r_state == S_CLR) begin
            r_waitCnt <= WAIT_LOAD;
         end else if ((r_state == S_WAIT) && (r_waitCnt != '0)) begin
            r_waitCnt <= r_waitCnt - CW'(1);
         end
         if (r_state == S_RD6) begin
            oDigest[63:32] <= idat;
         end
         if (r_state == S_CAP) begin
            oDigest[31:0] <= idat;
         end
      end
   end

endmodule
